// File: rtl/branch_resolver_if.sv
// Branch resolver bundle: fetch-stage prediction lookup, execute-stage resolve, registered redirect.
// Latency: prediction/direction/comparator mode 0 cycles; flush/redirect/illegal 1 cycle.
// Backpressure: none, the resolver accepts every cycle; BRANCH_PERF_EN adds the perf count outputs.
interface branch_resolver_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] i_fetch_pc;
  logic                  o_pred_taken;
  logic                  i_ex_valid;
  logic [2:0]            i_ex_funct3;
  logic [DATA_WIDTH-1:0] i_ex_pc;
  logic                  i_ex_pred_taken;
  logic                  o_BranchOp;
  logic                  BrEq;
  logic                  BrLT;
  logic                  o_taken;
  logic                  o_flush;
  logic                  o_redirect_taken;
  logic                  o_illegal;
`ifdef BRANCH_PERF_EN
  logic [31:0]           o_br_count;
  logic [31:0]           o_mispred_count;
`endif

  modport master (
`ifdef BRANCH_PERF_EN
    input  o_br_count,
    input  o_mispred_count,
`endif
    output i_fetch_pc,
    output i_ex_valid,
    output i_ex_funct3,
    output i_ex_pc,
    output i_ex_pred_taken,
    output BrEq,
    output BrLT,
    input  o_pred_taken,
    input  o_BranchOp,
    input  o_taken,
    input  o_flush,
    input  o_redirect_taken,
    input  o_illegal
  );

  modport slave (
`ifdef BRANCH_PERF_EN
    output o_br_count,
    output o_mispred_count,
`endif
    input  i_fetch_pc,
    input  i_ex_valid,
    input  i_ex_funct3,
    input  i_ex_pc,
    input  i_ex_pred_taken,
    input  BrEq,
    input  BrLT,
    output o_pred_taken,
    output o_BranchOp,
    output o_taken,
    output o_flush,
    output o_redirect_taken,
    output o_illegal
  );
endinterface

// File: rtl/branch_resolver.sv
// Conditional-branch resolver with a 2-bit saturating-counter BHT; BRANCH_PERF_EN adds perf counters.
// Latency: o_taken/o_pred_taken/o_BranchOp 0 cycles; flush, illegal and counter updates 1 cycle.
// Backpressure: none; a resolve arriving while o_flush is high is squashed.
module branch_resolver #(
  parameter int DATA_WIDTH  = 32,
  parameter int BHT_ENTRIES = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  branch_resolver_if.slave bus
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);

  typedef logic [1:0] ctr_t;
  localparam ctr_t CTR_RESET = 2'b01;
  localparam ctr_t CTR_MAX   = 2'b11;
  localparam ctr_t CTR_MIN   = 2'b00;

  ctr_t             bht [BHT_ENTRIES];
  logic [IDX_W-1:0] fetchIdx;
  logic [IDX_W-1:0] exIdx;
  ctr_t             exCtr;
  ctr_t             exCtrNext;

  logic flushQ;
  logic redirQ;
  logic illegalQ;
  logic live;
  logic legal;
  logic dirRaw;
  logic taken;
  logic accepted;
  logic mispred;
  logic illegalHit;

  assign fetchIdx = bus.i_fetch_pc[IDX_W+1:2];
  assign exIdx    = bus.i_ex_pc[IDX_W+1:2];

  // Lookup reads the array directly, so a same-cycle update is only seen after the edge.
  assign bus.o_pred_taken = bht[fetchIdx][1];
  assign bus.o_BranchOp   = bus.i_ex_funct3[2] & bus.i_ex_funct3[1];

  // The branch sitting in execute during a flush cycle is on the wrong path.
  assign live = bus.i_ex_valid & ~flushQ;

  always_comb begin
    legal  = 1'b1;
    dirRaw = 1'b0;
    case (bus.i_ex_funct3)
      3'b000:  dirRaw = bus.BrEq;
      3'b001:  dirRaw = ~bus.BrEq;
      3'b100:  dirRaw = bus.BrLT;
      3'b110:  dirRaw = bus.BrLT;
      3'b101:  dirRaw = ~bus.BrLT;
      3'b111:  dirRaw = ~bus.BrLT;
      default: legal  = 1'b0;
    endcase
  end

  assign taken       = live & legal & dirRaw;
  assign accepted    = live & legal;
  assign mispred     = accepted & (taken != bus.i_ex_pred_taken);
  assign illegalHit  = live & ~legal;
  assign bus.o_taken = taken;

  always_comb begin
    exCtr     = bht[exIdx];
    exCtrNext = exCtr;
    if (taken) begin
      if (exCtr != CTR_MAX) exCtrNext = exCtr + 2'd1;
    end else begin
      if (exCtr != CTR_MIN) exCtrNext = exCtr - 2'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= CTR_RESET;
      end
    end else if (accepted) begin
      bht[exIdx] <= exCtrNext;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      flushQ   <= 1'b0;
      redirQ   <= 1'b0;
      illegalQ <= 1'b0;
    end else begin
      flushQ   <= mispred;
      redirQ   <= mispred & taken;
      illegalQ <= illegalHit;
    end
  end

  assign bus.o_flush          = flushQ;
  assign bus.o_redirect_taken = redirQ;
  assign bus.o_illegal        = illegalQ;

`ifdef BRANCH_PERF_EN
  logic [31:0] brCount;
  logic [31:0] mispredCount;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      brCount      <= 32'd0;
      mispredCount <= 32'd0;
    end else begin
      if (accepted) brCount      <= brCount + 32'd1;
      if (mispred)  mispredCount <= mispredCount + 32'd1;
    end
  end

  assign bus.o_br_count      = brCount;
  assign bus.o_mispred_count = mispredCount;
`endif
endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: a reference BHT model drives a scoreboard of expected
// registered outputs (flush/redirect/illegal), popped one cycle after each stimulus.
module tb_branch_resolver;
  localparam int DW = 32;
  localparam int NE = 16;

  typedef struct packed {
    logic flush;
    logic redir;
    logic ill;
  } regExp_t;

  logic    clk  = 1'b0;
  logic    rstN = 1'b0;
  int      total = 0;
  int      bad   = 0;
  regExp_t expQ[$];
  logic [1:0] mdl [NE];
  bit      mFlush;
  int      mAcc;
  int      mMis;

  branch_resolver_if #(.DATA_WIDTH(DW)) bus ();

  branch_resolver #(
    .DATA_WIDTH (DW),
    .BHT_ENTRIES(NE)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rstN),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic refDir(logic [2:0] f3, logic eq, logic lt);
    case (f3)
      3'b000:  return eq;
      3'b001:  return !eq;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return lt;
      3'b111:  return !lt;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int idxOf(logic [DW-1:0] pc);
    return int'(pc[5:2]);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NE; i++) mdl[i] = 2'b01;
    mFlush = 1'b0;
    mAcc   = 0;
    mMis   = 0;
    expQ.delete();
  endtask

  // One execute-stage branch for one cycle; checks combinational outputs, then the registered ones.
  task automatic resolve(string name, logic [DW-1:0] pc, logic [2:0] f3,
                         logic eq, logic lt, logic pred);
    logic    legal, tk, acc, mis, ill, expPred, expOp;
    int      ix;
    regExp_t e, got;
    @(negedge clk);
    bus.i_ex_valid      = 1'b1;
    bus.i_ex_pc         = pc;
    bus.i_ex_funct3     = f3;
    bus.BrEq            = eq;
    bus.BrLT            = lt;
    bus.i_ex_pred_taken = pred;
    legal   = !(f3 == 3'b010 || f3 == 3'b011);
    tk      = !mFlush && legal && refDir(f3, eq, lt);
    acc     = !mFlush && legal;
    mis     = acc && (tk != pred);
    ill     = !mFlush && !legal;
    expOp   = (f3 == 3'b110 || f3 == 3'b111);
    expPred = mdl[idxOf(bus.i_fetch_pc)][1];
    expQ.push_back(regExp_t'{mis, mis & tk, ill});
    #1;
    total++;
    if (bus.o_taken !== tk) begin
      bad++;
      $display("FAIL %s o_taken: got %b want %b", name, bus.o_taken, tk);
    end
    total++;
    if (bus.o_BranchOp !== expOp) begin
      bad++;
      $display("FAIL %s o_BranchOp: got %b want %b", name, bus.o_BranchOp, expOp);
    end
    total++;
    if (bus.o_pred_taken !== expPred) begin
      bad++;
      $display("FAIL %s o_pred_taken(pre-update): got %b want %b", name, bus.o_pred_taken, expPred);
    end
    if (acc) begin
      ix = idxOf(pc);
      if (tk) begin
        if (mdl[ix] != 2'b11) mdl[ix] = mdl[ix] + 2'd1;
      end else begin
        if (mdl[ix] != 2'b00) mdl[ix] = mdl[ix] - 2'd1;
      end
      mAcc++;
    end
    if (mis) mMis++;
    @(posedge clk);
    #1;
    mFlush = mis;
    got = {bus.o_flush, bus.o_redirect_taken, bus.o_illegal};
    total++;
    if (expQ.size() == 0) begin
      bad++;
      $display("FAIL %s scoreboard: got %b want <empty queue>", name, got);
    end else begin
      e = expQ.pop_front();
      if (got !== e) begin
        bad++;
        $display("FAIL %s flush/redir/illegal: got %b want %b", name, got, e);
      end
    end
    bus.i_ex_valid = 1'b0;
  endtask

  // One idle cycle with a fetch lookup; also drains the registered outputs.
  task automatic lookup(string name, logic [DW-1:0] pc, logic exp);
    regExp_t e, got;
    @(negedge clk);
    bus.i_ex_valid = 1'b0;
    bus.i_fetch_pc = pc;
    expQ.push_back(regExp_t'(3'b000));
    #1;
    total++;
    if (bus.o_pred_taken !== exp) begin
      bad++;
      $display("FAIL %s o_pred_taken: got %b want %b", name, bus.o_pred_taken, exp);
    end
    @(posedge clk);
    #1;
    mFlush = 1'b0;
    got = {bus.o_flush, bus.o_redirect_taken, bus.o_illegal};
    total++;
    e = expQ.pop_front();
    if (got !== e) begin
      bad++;
      $display("FAIL %s idle flush/redir/illegal: got %b want %b", name, got, e);
    end
  endtask

  task automatic checkPerf(string name);
`ifdef BRANCH_PERF_EN
    total++;
    if (bus.o_br_count !== 32'(mAcc)) begin
      bad++;
      $display("FAIL %s o_br_count: got %0d want %0d", name, bus.o_br_count, mAcc);
    end
    total++;
    if (bus.o_mispred_count !== 32'(mMis)) begin
      bad++;
      $display("FAIL %s o_mispred_count: got %0d want %0d", name, bus.o_mispred_count, mMis);
    end
`else
    if (name.len() == 0) $display("perf counters absent");
`endif
  endtask

  task automatic test_reset();
    bus.i_fetch_pc      = '0;
    bus.i_ex_valid      = 1'b0;
    bus.i_ex_funct3     = 3'b000;
    bus.i_ex_pc         = '0;
    bus.i_ex_pred_taken = 1'b0;
    bus.BrEq            = 1'b0;
    bus.BrLT            = 1'b0;
    rstN                = 1'b0;
    modelReset();
    #1;
    total++;
    if ({bus.o_flush, bus.o_redirect_taken, bus.o_illegal} !== 3'b000) begin
      bad++;
      $display("FAIL reset_regs: got %b want 000",
               {bus.o_flush, bus.o_redirect_taken, bus.o_illegal});
    end
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    checkPerf("reset_perf");
    lookup("reset_pred_0x40", 32'h40, 1'b0);
  endtask

  task automatic test_beq_mispredict();
    resolve("beq_mispred", 32'h40, 3'b000, 1'b1, 1'b0, 1'b0);
    lookup("beq_after", 32'h40, 1'b1);
  endtask

  task automatic test_bltu_saturate();
    for (int i = 0; i < 4; i++) resolve("bltu_taken", 32'h44, 3'b110, 1'b0, 1'b1, 1'b1);
    lookup("bltu_sat", 32'h44, 1'b1);
    resolve("bltu_nt", 32'h44, 3'b110, 1'b0, 1'b0, 1'b1);
    lookup("bltu_after_nt", 32'h44, 1'b1);
  endtask

  task automatic test_compare_modes();
    resolve("blt",     32'h60, 3'b100, 1'b0, 1'b1, 1'b1);
    resolve("bge",     32'h64, 3'b101, 1'b0, 1'b0, 1'b1);
    resolve("bgeu_nt", 32'h68, 3'b111, 1'b0, 1'b1, 1'b0);
    resolve("bne_eq",  32'h6C, 3'b001, 1'b1, 1'b0, 1'b0);
    resolve("bne_mis", 32'h70, 3'b001, 1'b0, 1'b0, 1'b0);
    lookup("bne_after", 32'h70, 1'b1);
    resolve("beq_nt",  32'h74, 3'b000, 1'b0, 1'b1, 1'b1);
    lookup("beq_nt_after", 32'h74, 1'b0);
  endtask

  task automatic test_illegal();
    lookup("ill_before", 32'h4C, 1'b0);
    resolve("rsv011", 32'h4C, 3'b011, 1'b1, 1'b1, 1'b0);
    lookup("ill_once", 32'h4C, 1'b0);
    resolve("rsv010", 32'h4C, 3'b010, 1'b1, 1'b1, 1'b1);
    lookup("ill_after", 32'h4C, 1'b0);
  endtask

  task automatic test_back_to_back_squash();
    resolve("sq_a", 32'h50, 3'b000, 1'b1, 1'b0, 1'b0);
    resolve("sq_b", 32'h58, 3'b000, 1'b1, 1'b0, 1'b1);
    lookup("sq_b_noupd", 32'h58, 1'b0);
    resolve("sq_c", 32'h50, 3'b000, 1'b1, 1'b0, 1'b0);
    resolve("sq_d", 32'h58, 3'b001, 1'b1, 1'b0, 1'b1);
    resolve("sq_e", 32'h50, 3'b000, 1'b1, 1'b0, 1'b0);
    resolve("sq_f", 32'h4C, 3'b011, 1'b0, 1'b0, 1'b0);
    lookup("sq_end", 32'h58, 1'b0);
  endtask

  task automatic test_same_index();
    lookup("same_before", 32'h78, 1'b0);
    resolve("same_idx", 32'h78, 3'b000, 1'b1, 1'b0, 1'b1);
    lookup("same_after", 32'h78, 1'b1);
    checkPerf("run_perf");
  endtask

  task automatic test_reset_midflight();
    // A pending flush is cleared asynchronously.
    resolve("mf_a", 32'h5C, 3'b000, 1'b1, 1'b0, 1'b0);
    #1 rstN = 1'b0;
    #1;
    total++;
    if ({bus.o_flush, bus.o_redirect_taken} !== 2'b00) begin
      bad++;
      $display("FAIL mf_async_clear: got %b want 00", {bus.o_flush, bus.o_redirect_taken});
    end
    modelReset();
    @(negedge clk);
    rstN = 1'b1;
    // Mispredict in execute, reset asserted before the edge that would register it.
    @(negedge clk);
    bus.i_ex_valid      = 1'b1;
    bus.i_ex_pc         = 32'h40;
    bus.i_ex_funct3     = 3'b000;
    bus.BrEq            = 1'b1;
    bus.i_ex_pred_taken = 1'b0;
    #1;
    total++;
    if (bus.o_taken !== 1'b1) begin
      bad++;
      $display("FAIL mf_taken: got %b want 1", bus.o_taken);
    end
    #2 rstN = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({bus.o_flush, bus.o_illegal} !== 2'b00) begin
      bad++;
      $display("FAIL mf_no_flush: got %b want 00", {bus.o_flush, bus.o_illegal});
    end
    bus.i_ex_valid = 1'b0;
    checkPerf("mf_perf_reset");
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({bus.o_flush, bus.o_redirect_taken, bus.o_illegal} !== 3'b000) begin
      bad++;
      $display("FAIL mf_fresh: got %b want 000",
               {bus.o_flush, bus.o_redirect_taken, bus.o_illegal});
    end
    for (int i = 0; i < NE; i++) lookup("mf_ctr01", DW'(i * 4), 1'b0);
    resolve("mf_post", 32'h40, 3'b000, 1'b1, 1'b0, 1'b0);
    lookup("mf_post_after", 32'h40, 1'b1);
    checkPerf("mf_perf_post");
  endtask

  initial begin
    test_reset();
    test_beq_mispredict();
    test_bltu_saturate();
    test_compare_modes();
    test_illegal();
    test_back_to_back_squash();
    test_same_index();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
